fan_timer_countdown: RTL and testbench



---
 rtl/fan_timer_countdown_pkg.sv | 39 +++
 rtl/fan_timer_countdown_bcd_mmss_down.sv | 40 ++++
 rtl/fan_timer_countdown.sv | 137 +++++++++++++
 tb/tb_fan_timer_countdown.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_timer_countdown_pkg.sv
// Shared types and helpers for the fan timer countdown engine and the timer-select FSM.
package fan_timer_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] TSEL_OFF = 2'd0;
  localparam logic [1:0] TSEL_1   = 2'd1;
  localparam logic [1:0] TSEL_2   = 2'd2;
  localparam logic [1:0] TSEL_3   = 2'd3;

  localparam int unsigned SEC_W = 13;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  // Constant-foldable so preset digits are computed at elaboration.
  function automatic mmss_t secs_to_mmss(input int unsigned secs);
    int unsigned m;
    int unsigned s;
    mmss_t       d;
    m = secs / 60;
    s = secs % 60;
    d.min_tens = 4'(m / 10);
    d.min_ones = 4'(m % 10);
    d.sec_tens = 4'(s / 10);
    d.sec_ones = 4'(s % 10);
    return d;
  endfunction

endpackage

// File: rtl/fan_timer_countdown_bcd_mmss_down.sv
// Four-digit mm:ss BCD down counter with clear, load and decrement-enable.
module fan_timer_countdown_bcd_mmss_down
  import fan_timer_countdown_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  load,
  input  mmss_t load_val,
  input  logic  dec,
  output mmss_t digits
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      digits <= '0;
    end else if (load) begin
      digits <= load_val;
    end else if (dec) begin
      // Borrow ripples sec_ones -> sec_tens -> min_ones -> min_tens.
      if (digits.sec_ones != 4'd0) begin
        digits.sec_ones <= digits.sec_ones - 4'd1;
      end else begin
        digits.sec_ones <= 4'd9;
        if (digits.sec_tens != 4'd0) begin
          digits.sec_tens <= digits.sec_tens - 4'd1;
        end else begin
          digits.sec_tens <= 4'd5;
          if (digits.min_ones != 4'd0) begin
            digits.min_ones <= digits.min_ones - 4'd1;
          end else begin
            digits.min_ones <= 4'd9;
            digits.min_tens <= digits.min_tens - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fan_timer_countdown.sv
// Fan timer countdown: loads a preset, decrements once per tick while the fan runs,
// and reports remaining time in binary and mm:ss BCD with tick/expiry strobes.
module fan_timer_countdown
  import fan_timer_countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned PRESET_1 = 60,
  parameter int unsigned PRESET_2 = 180,
  parameter int unsigned PRESET_3 = 300
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_timer_sel,
  input  logic             i_load,
  input  logic             i_cancel,
  input  logic             i_fan_on,
  output logic [SEC_W-1:0] o_remaining,
  output logic [3:0]       o_min_tens,
  output logic [3:0]       o_min_ones,
  output logic [3:0]       o_sec_tens,
  output logic [3:0]       o_sec_ones,
  output logic             o_running,
  output logic             o_tick,
  output logic             o_expire
);

  localparam int unsigned     PS_W    = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  localparam mmss_t BCD_1 = secs_to_mmss(PRESET_1);
  localparam mmss_t BCD_2 = secs_to_mmss(PRESET_2);
  localparam mmss_t BCD_3 = secs_to_mmss(PRESET_3);

  state_t           state_q;
  logic [PS_W-1:0]  prescale_q;
  logic [SEC_W-1:0] preset_sec;
  mmss_t            preset_bcd;
  mmss_t            digits;
  logic             cancel_evt;
  logic             load_evt;
  logic             tick_evt;

  always_comb begin
    preset_sec = '0;
    preset_bcd = '0;
    case (i_timer_sel)
      TSEL_1: begin
        preset_sec = SEC_W'(PRESET_1);
        preset_bcd = BCD_1;
      end
      TSEL_2: begin
        preset_sec = SEC_W'(PRESET_2);
        preset_bcd = BCD_2;
      end
      TSEL_3: begin
        preset_sec = SEC_W'(PRESET_3);
        preset_bcd = BCD_3;
      end
      default: ;
    endcase
  end

  // A load with selection "off" behaves exactly like a cancel.
  assign cancel_evt = i_cancel || (i_load && (i_timer_sel == TSEL_OFF));
  assign load_evt   = !i_cancel && i_load && (i_timer_sel != TSEL_OFF);
  assign tick_evt   = (state_q == ST_RUN) && (prescale_q == PS_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      prescale_q  <= '0;
      o_remaining <= '0;
      o_running   <= 1'b0;
      o_tick      <= 1'b0;
      o_expire    <= 1'b0;
    end else begin
      o_tick   <= 1'b0;
      o_expire <= 1'b0;
      if (cancel_evt) begin
        state_q     <= ST_IDLE;
        prescale_q  <= '0;
        o_remaining <= '0;
        o_running   <= 1'b0;
      end else if (load_evt) begin
        state_q     <= i_fan_on ? ST_RUN : ST_PAUSE;
        prescale_q  <= '0;
        o_remaining <= preset_sec;
        o_running   <= 1'b1;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (tick_evt) begin
              prescale_q  <= '0;
              o_remaining <= o_remaining - SEC_W'(1);
              o_tick      <= 1'b1;
              if (o_remaining == SEC_W'(1)) begin
                state_q   <= ST_DONE;
                o_running <= 1'b0;
                o_expire  <= 1'b1;
              end else if (!i_fan_on) begin
                state_q <= ST_PAUSE;
              end
            end else begin
              prescale_q <= prescale_q + PS_W'(1);
              if (!i_fan_on) begin
                state_q <= ST_PAUSE;
              end
            end
          end
          ST_PAUSE: begin
            if (i_fan_on) begin
              state_q <= ST_RUN;
            end
          end
          ST_DONE:  state_q <= ST_IDLE;
          default:  ;
        endcase
      end
    end
  end

  fan_timer_countdown_bcd_mmss_down u_digits (
    .clk      (i_clk),
    .reset    (i_reset),
    .clear    (cancel_evt),
    .load     (load_evt),
    .load_val (preset_bcd),
    .dec      (tick_evt && !cancel_evt && !load_evt),
    .digits   (digits)
  );

  assign o_min_tens = digits.min_tens;
  assign o_min_ones = digits.min_ones;
  assign o_sec_tens = digits.sec_tens;
  assign o_sec_ones = digits.sec_ones;

endmodule

// File: tb/tb_fan_timer_countdown.sv
// Self-checking bench for fan_timer_countdown with a tick-event scoreboard.
module tb_fan_timer_countdown;

  localparam int unsigned TD = 4;
  localparam int unsigned P1 = 3;
  localparam int unsigned P2 = 61;
  localparam int unsigned P3 = 5999;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  i_timer_sel = 2'd0;
  logic        i_load = 1'b0;
  logic        i_cancel = 1'b0;
  logic        i_fan_on = 1'b0;
  logic [12:0] o_remaining;
  logic [3:0]  o_min_tens, o_min_ones, o_sec_tens, o_sec_ones;
  logic        o_running, o_tick, o_expire;

  fan_timer_countdown #(
    .TICK_DIV (TD),
    .PRESET_1 (P1),
    .PRESET_2 (P2),
    .PRESET_3 (P3)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_timer_sel (i_timer_sel),
    .i_load      (i_load),
    .i_cancel    (i_cancel),
    .i_fan_on    (i_fan_on),
    .o_remaining (o_remaining),
    .o_min_tens  (o_min_tens),
    .o_min_ones  (o_min_ones),
    .o_sec_tens  (o_sec_tens),
    .o_sec_ones  (o_sec_ones),
    .o_running   (o_running),
    .o_tick      (o_tick),
    .o_expire    (o_expire)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int unsigned cyc;
    int unsigned rem;
    bit          expire;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [15:0] mmss(input int unsigned s);
    int unsigned m;
    int unsigned r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  function automatic logic [15:0] digs();
    return {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_load(input logic [1:0] sel);
    i_timer_sel = sel;
    i_load = 1'b1;
    step();
    i_load = 1'b0;
  endtask

  task automatic do_cancel();
    i_cancel = 1'b1;
    step();
    i_cancel = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({o_remaining, digs(), o_running, o_tick, o_expire} !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d rem=%0d digits=%h run=%b tick=%b exp=%b, expected all 0",
                 cyc, o_remaining, digs(), o_running, o_tick, o_expire);
      end
    end
  endtask

  task automatic test_countdown();
    int unsigned c0;
    int unsigned n_exp;
    ev_t e;
    i_fan_on = 1'b1;
    do_load(2'd1);
    c0 = cyc;
    n_cmp++;
    if ({o_remaining, digs(), o_running} !== {13'(P1), mmss(P1), 1'b1}) begin
      n_bad++;
      $display("FAIL cd_load rem=%0d digits=%h run=%b, expected rem=%0d digits=%h run=1",
               o_remaining, digs(), o_running, P1, mmss(P1));
    end
    sb.push_back('{c0 + 4, 2, 1'b0});
    sb.push_back('{c0 + 8, 1, 1'b0});
    sb.push_back('{c0 + 12, 0, 1'b1});
    n_exp = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (o_expire) n_exp++;
      if (o_tick || o_expire) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL cd_event unexpected at cyc=%0d rem=%0d", cyc, o_remaining);
        end else begin
          e = sb.pop_front();
          if ({32'(cyc), o_remaining, o_tick, o_expire, digs()} !==
              {32'(e.cyc), 13'(e.rem), 1'b1, e.expire, mmss(e.rem)}) begin
            n_bad++;
            $display("FAIL cd_event cyc=%0d rem=%0d tick=%b exp=%b digits=%h, expected cyc=%0d rem=%0d tick=1 exp=%b digits=%h",
                     cyc, o_remaining, o_tick, o_expire, digs(), e.cyc, e.rem, e.expire, mmss(e.rem));
          end
        end
      end
    end
    n_cmp++;
    if ({32'(sb.size()), 32'(n_exp), o_running, o_remaining} !== {32'd0, 32'd1, 1'b0, 13'd0}) begin
      n_bad++;
      $display("FAIL cd_end pending=%0d expires=%0d run=%b rem=%0d, expected 0/1/0/0",
               sb.size(), n_exp, o_running, o_remaining);
    end
    sb.delete();
  endtask

  task automatic test_borrow();
    int unsigned c0;
    ev_t e;
    do_load(2'd2);
    c0 = cyc;
    n_cmp++;
    if ({o_remaining, digs()} !== {13'd61, 16'h0101}) begin
      n_bad++;
      $display("FAIL borrow_load rem=%0d digits=%h, expected rem=61 digits=0101", o_remaining, digs());
    end
    sb.push_back('{c0 + 4, 60, 1'b0});
    sb.push_back('{c0 + 8, 59, 1'b0});
    for (int i = 0; i < 9; i++) begin
      step();
      if (o_tick) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL borrow_tick unexpected at cyc=%0d rem=%0d", cyc, o_remaining);
        end else begin
          e = sb.pop_front();
          if ({32'(cyc), o_remaining, o_expire, digs()} !==
              {32'(e.cyc), 13'(e.rem), e.expire, mmss(e.rem)}) begin
            n_bad++;
            $display("FAIL borrow_tick cyc=%0d rem=%0d exp=%b digits=%h, expected cyc=%0d rem=%0d exp=%b digits=%h",
                     cyc, o_remaining, o_expire, digs(), e.cyc, e.rem, e.expire, mmss(e.rem));
          end
        end
      end
    end
    n_cmp++;
    if ({32'(sb.size()), o_remaining, digs()} !== {32'd0, 13'd59, 16'h0059}) begin
      n_bad++;
      $display("FAIL borrow_end pending=%0d rem=%0d digits=%h, expected 0 / 59 / 0059",
               sb.size(), o_remaining, digs());
    end
    sb.delete();
    do_cancel();
  endtask

  task automatic test_max();
    int unsigned c0;
    int unsigned span;
    int unsigned v;
    ev_t e;
    do_load(2'd3);
    c0 = cyc;
    n_cmp++;
    if ({o_remaining, digs()} !== {13'd5999, 16'h9959}) begin
      n_bad++;
      $display("FAIL max_load rem=%0d digits=%h, expected rem=5999 digits=9959", o_remaining, digs());
    end
    for (int k = 1; k <= 16; k++) sb.push_back('{c0 + 4 * k, 5999 - k, 1'b0});
    span = $urandom_range(24, 60);
    for (int unsigned i = 0; i < span; i++) begin
      step();
      v = 60 * (10 * o_min_tens + o_min_ones) + 10 * o_sec_tens + o_sec_ones;
      n_cmp++;
      if (v !== 32'(o_remaining) || o_sec_tens > 4'd5 || o_sec_ones > 4'd9 || o_min_ones > 4'd9) begin
        n_bad++;
        $display("FAIL max_invariant cyc=%0d digits=%h (=%0d s) rem=%0d, expected consistent mm:ss",
                 cyc, digs(), v, o_remaining);
      end
      if (o_tick) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL max_tick unexpected at cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if ({32'(cyc), o_remaining, digs()} !== {32'(e.cyc), 13'(e.rem), mmss(e.rem)}) begin
            n_bad++;
            $display("FAIL max_tick cyc=%0d rem=%0d digits=%h, expected cyc=%0d rem=%0d digits=%h",
                     cyc, o_remaining, digs(), e.cyc, e.rem, mmss(e.rem));
          end
        end
      end
    end
    sb.delete();
    do_cancel();
  endtask

  task automatic test_pause();
    int unsigned c0;
    ev_t e;
    i_fan_on = 1'b1;
    do_load(2'd2);
    c0 = cyc;
    step();
    step();
    i_fan_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({o_remaining, o_tick, o_running} !== {13'd61, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL pause_hold cyc=%0d rem=%0d tick=%b run=%b, expected rem=61 tick=0 run=1",
                 cyc, o_remaining, o_tick, o_running);
      end
    end
    i_fan_on = 1'b1;
    sb.push_back('{c0 + 14, 60, 1'b0});
    sb.push_back('{c0 + 18, 59, 1'b0});
    for (int i = 0; i < 7; i++) begin
      step();
      if (o_tick) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL pause_tick unexpected at cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if ({32'(cyc), o_remaining} !== {32'(e.cyc), 13'(e.rem)}) begin
            n_bad++;
            $display("FAIL pause_tick cyc=%0d rem=%0d, expected cyc=%0d rem=%0d",
                     cyc, o_remaining, e.cyc, e.rem);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL pause_pending got %0d outstanding ticks, expected 0", sb.size());
    end
    sb.delete();
    do_cancel();
  endtask

  task automatic test_cancel_load();
    int unsigned c1;
    int unsigned n_ev;
    ev_t e;
    i_fan_on = 1'b1;
    do_load(2'd2);
    step();
    step();
    i_cancel = 1'b1;
    i_timer_sel = 2'd2;
    i_load = 1'b1;
    step();
    i_cancel = 1'b0;
    i_load = 1'b0;
    n_cmp++;
    if ({o_remaining, digs(), o_running, o_tick, o_expire} !== 32'd0) begin
      n_bad++;
      $display("FAIL cancel_wins rem=%0d digits=%h run=%b tick=%b exp=%b, expected all 0",
               o_remaining, digs(), o_running, o_tick, o_expire);
    end
    n_ev = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_tick || o_expire || o_remaining != 13'd0) n_ev++;
    end
    n_cmp++;
    if (n_ev !== 0) begin
      n_bad++;
      $display("FAIL cancel_quiet got %0d active cycles after cancel, expected 0", n_ev);
    end
    do_load(2'd2);
    step();
    do_load(2'd0);
    n_cmp++;
    if ({o_remaining, o_running, digs()} !== {13'd0, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL sel0_cancel rem=%0d run=%b digits=%h, expected 0/0/0000",
               o_remaining, o_running, digs());
    end
    do_load(2'd1);
    step();
    step();
    step();
    do_load(2'd2);
    c1 = cyc;
    n_cmp++;
    if ({o_remaining, o_tick, digs()} !== {13'd61, 1'b0, 16'h0101}) begin
      n_bad++;
      $display("FAIL load_on_tick rem=%0d tick=%b digits=%h, expected rem=61 tick=0 digits=0101",
               o_remaining, o_tick, digs());
    end
    sb.push_back('{c1 + 4, 60, 1'b0});
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_tick) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL reload_tick unexpected at cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if ({32'(cyc), o_remaining} !== {32'(e.cyc), 13'(e.rem)}) begin
            n_bad++;
            $display("FAIL reload_tick cyc=%0d rem=%0d, expected cyc=%0d rem=%0d",
                     cyc, o_remaining, e.cyc, e.rem);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL reload_pending got %0d outstanding ticks, expected 0", sb.size());
    end
    sb.delete();
    do_cancel();
  endtask

  task automatic test_fan_edges();
    int unsigned n_ev;
    i_fan_on = 1'b1;
    do_load(2'd2);
    step();
    step();
    step();
    i_fan_on = 1'b0;
    step();
    n_cmp++;
    if ({o_remaining, o_tick, o_running} !== {13'd60, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL tick_fan_fall rem=%0d tick=%b run=%b, expected rem=60 tick=1 run=1",
               o_remaining, o_tick, o_running);
    end
    n_ev = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_tick || o_remaining != 13'd60) n_ev++;
    end
    n_cmp++;
    if (n_ev !== 0) begin
      n_bad++;
      $display("FAIL fall_then_pause got %0d changing cycles, expected 0", n_ev);
    end
    do_cancel();
    do_load(2'd1);
    n_ev = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_tick || o_remaining != 13'(P1) || !o_running) n_ev++;
    end
    n_cmp++;
    if (n_ev !== 0) begin
      n_bad++;
      $display("FAIL load_fan_off got %0d non-paused cycles, expected 0", n_ev);
    end
    i_fan_on = 1'b1;
    do_load(2'd1);
    for (int i = 0; i < 11; i++) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    n_cmp++;
    if ({o_remaining, digs(), o_running, o_tick, o_expire} !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid rem=%0d digits=%h run=%b tick=%b exp=%b, expected all 0",
               o_remaining, digs(), o_running, o_tick, o_expire);
    end
    i_fan_on = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_max();
    test_pause();
    test_cancel_load();
    test_fan_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
